// File: rtl/linebuffer_3x3_ctrl.sv
// Frame sequencer for linebuffer_3x3: valid/ready pixel intake, shift gating and 3x3 window flagging.
// Optional feature macro STRIDE2_EN adds cfg_stride2 (windows only at even row/col offsets).
module linebuffer_3x3_ctrl #(
  parameter int DW    = 16,
  parameter int MAX_W = 64,
  parameter int MAX_H = 64,
  localparam int CW   = $clog2(MAX_W + 1),
  localparam int RW   = $clog2(MAX_H + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_img_w,
  input  logic [RW-1:0] cfg_img_h,
`ifdef STRIDE2_EN
  input  logic          cfg_stride2,
`endif
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          lb_en,
  output logic [DW-1:0] lb_data,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state, state_n;
  logic [CW-1:0] img_w;
  logic [RW-1:0] img_h;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          cfg_ok;
  logic          accept_start;
  logic          col_last;
  logic          frame_last;
  logic          win_hit;
  logic          flush_ok;

  assign cfg_ok = (cfg_img_w >= CW'(3)) && (cfg_img_w <= CW'(MAX_W)) &&
                  (cfg_img_h >= RW'(3)) && (cfg_img_h <= RW'(MAX_H));
  assign accept_start = (state == IDLE) && start && cfg_ok;
  assign col_last     = (col == img_w - CW'(1));
  assign frame_last   = col_last && (row == img_h - RW'(1));
  assign flush_ok     = !win_valid || win_ready;

`ifdef STRIDE2_EN
  logic stride2;
  // (row-2) and (col-2) share parity with row and col, so the LSBs decide.
  assign win_hit = (row >= RW'(2)) && (col >= CW'(2)) &&
                   (!stride2 || (!row[0] && !col[0]));
`else
  assign win_hit = (row >= RW'(2)) && (col >= CW'(2));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    s_ready = 1'b0;
    case (state)
      IDLE: begin
        if (accept_start) state_n = RUN;
      end
      RUN: begin
        // Hold the shift while an unconsumed window sits in ifmap_3x3.
        s_ready = !win_valid || win_ready;
        if (s_valid && s_ready && frame_last) state_n = FLUSH;
      end
      FLUSH: begin
        if (flush_ok) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign lb_en   = s_valid && s_ready;
  assign lb_data = s_data;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      img_w     <= '0;
      img_h     <= '0;
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= (state == FLUSH) && flush_ok;
      cfg_err <= (state == IDLE) && start && !cfg_ok;

      if (accept_start) begin
        img_w <= cfg_img_w;
        img_h <= cfg_img_h;
        row   <= '0;
        col   <= '0;
      end else if (lb_en) begin
        if (col_last) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      if (lb_en && win_hit) begin
        win_valid <= 1'b1;
        win_row   <= row - RW'(2);
        win_col   <= col - CW'(2);
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef STRIDE2_EN
  always_ff @(posedge clk) begin
    if (rst)               stride2 <= 1'b0;
    else if (accept_start) stride2 <= cfg_stride2;
  end
`endif

endmodule

// File: tb/tb_linebuffer_3x3_ctrl.sv
// Self-checking bench for linebuffer_3x3_ctrl: cycle tables for T1/T3/T4, scoreboarded frames for T2/T5/T6.
module tb_linebuffer_3x3_ctrl;
  localparam int DW    = 16;
  localparam int MAX_W = 64;
  localparam int MAX_H = 64;
  localparam int CW    = $clog2(MAX_W + 1);
  localparam int RW    = $clog2(MAX_H + 1);

  logic          clk = 1'b0;
  logic          rst, start, s_valid, win_ready;
  logic [CW-1:0] cfg_img_w;
  logic [RW-1:0] cfg_img_h;
  logic [DW-1:0] s_data;
  logic          s_ready, lb_en, win_valid, busy, done, cfg_err;
  logic [DW-1:0] lb_data;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
`ifdef STRIDE2_EN
  logic          cfg_stride2;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  linebuffer_3x3_ctrl #(.DW(DW), .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
`ifdef STRIDE2_EN
    .cfg_stride2(cfg_stride2),
`endif
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .lb_en(lb_en), .lb_data(lb_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic [CW-1:0] w;
    logic [RW-1:0] h;
    logic          sv;
    logic [DW-1:0] data;
    logic          wr;
    logic          e_sr, e_lb, e_wv;
    logic [RW-1:0] e_r;
    logic [CW-1:0] e_c;
    logic          e_busy, e_done, e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic void add(input logic st, input int w, input int h, input logic sv,
                              input int d, input logic wr, input logic sr, input logic lb,
                              input logic wv, input int r, input int c, input logic bz,
                              input logic dn, input logic er);
    vec_t v;
    v.st = st; v.w = CW'(w); v.h = RW'(h); v.sv = sv; v.data = DW'(d); v.wr = wr;
    v.e_sr = sr; v.e_lb = lb; v.e_wv = wv; v.e_r = RW'(r); v.e_c = CW'(c);
    v.e_busy = bz; v.e_done = dn; v.e_err = er;
    tbl.push_back(v);
  endfunction

  // W=4,H=4, pixels 1..16 back to back with win_ready held high.
  function automatic void fill_t1();
    tbl.delete();
    add(1, 4, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      logic wv; int r, c;
      wv = (k == 12) || (k == 13) || (k == 16);
      r  = (k == 16) ? 1 : 0;
      c  = (k == 13) ? 1 : 0;
      add(0, 4, 4, 1, k, 1, 1, 1, wv, r, c, 1, 0, 0);
    end
    add(0, 4, 4, 0, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0);
    add(0, 4, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 4, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void fill_t3();
    tbl.delete();
    add(1, 2, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 2, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 3, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 3, 3, 1, k, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    add(0, 3, 3, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 3, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 3, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply_table(input string nm);
    foreach (tbl[i]) begin
      @(negedge clk);
      start = tbl[i].st; cfg_img_w = tbl[i].w; cfg_img_h = tbl[i].h;
      s_valid = tbl[i].sv; s_data = tbl[i].data; win_ready = tbl[i].wr;
      #1;
      check($sformatf("%s[%0d] sr/lb/wv/busy/done/err", nm, i),
            {s_ready, lb_en, win_valid, busy, done, cfg_err},
            {tbl[i].e_sr, tbl[i].e_lb, tbl[i].e_wv, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err});
      if (tbl[i].e_wv)
        check($sformatf("%s[%0d] win_row/col", nm, i), {win_row, win_col}, {tbl[i].e_r, tbl[i].e_c});
      if (tbl[i].sv)
        check($sformatf("%s[%0d] lb_data", nm, i), lb_data, tbl[i].data);
    end
    @(negedge clk);
    start = 1'b0; s_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] pix(input int i);
    return DW'(i * 3 + 1);
  endfunction

  // Streams a full frame and scoreboards windows against the raster/stride expectation.
  task automatic run_frame(input string nm, input int w, input int h, input bit gaps,
                           input bit hold3, input bit s2);
    int er[64], ec[64];
    int n_exp = 0, nwin = 0, pushes = 0, pend = 0, step;
    bit seen_cur = 0, done_seen = 0;
    logic [RW-1:0] hr;
    logic [CW-1:0] hc;
    step = s2 ? 2 : 1;
    for (int r = 0; r <= h - 3; r += step)
      for (int c = 0; c <= w - 3; c += step) begin
        er[n_exp] = r; ec[n_exp] = c; n_exp++;
      end
    @(negedge clk);
    start = 1'b1; cfg_img_w = CW'(w); cfg_img_h = RW'(h); s_valid = 1'b0; win_ready = 1'b1;
`ifdef STRIDE2_EN
    cfg_stride2 = s2;
`endif
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      if (cyc != 0) @(negedge clk);
      win_ready = hold3 ? (win_valid && pend >= 3) : 1'b1;
      s_valid   = (pushes < w * h) && (gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
      s_data    = pix(pushes);
      #1;
      if (win_valid && !seen_cur) begin
        if (nwin < n_exp) begin
          check($sformatf("%s win%0d pos", nm, nwin), {win_row, win_col},
                {RW'(er[nwin]), CW'(ec[nwin])});
          check($sformatf("%s win%0d latency", nm, nwin), pushes,
                (er[nwin] + 2) * w + ec[nwin] + 3);
        end else begin
          check($sformatf("%s extra window", nm), nwin, n_exp);
        end
        nwin++;
        seen_cur = 1;
      end
      if (win_valid && !win_ready) begin
        check($sformatf("%s stall sr/lb", nm), {s_ready, lb_en}, 2'b00);
        if (pend == 0) begin hr = win_row; hc = win_col; end
        else check($sformatf("%s hold pos", nm), {win_row, win_col}, {hr, hc});
        pend++;
      end
      if (win_valid && win_ready) begin seen_cur = 0; pend = 0; end
      if (lb_en) begin
        if (pushes < 4) check($sformatf("%s lb_data%0d", nm, pushes), lb_data, pix(pushes));
        pushes++;
      end
      if (done) done_seen = 1;
    end
    check($sformatf("%s window count", nm), nwin, n_exp);
    check($sformatf("%s pixel count", nm), pushes, w * h);
    check($sformatf("%s done seen", nm), done_seen, 1);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check($sformatf("%s idle after", nm), {busy, done, win_valid}, 3'b000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; win_ready = 1'b0;
    cfg_img_w = '0; cfg_img_h = '0; s_data = '0;
`ifdef STRIDE2_EN
    cfg_stride2 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", {s_ready, lb_en, win_valid, busy, done, cfg_err, win_row, win_col}, '0);
    rst = 1'b0;

    fill_t1();
    apply_table("t1");

    run_frame("t2", 5, 4, 0, 1, 0);

    fill_t3();
    apply_table("t3");

    // Reset in the middle of a W=8,H=8 frame after 20 pixels.
    @(negedge clk);
    start = 1'b1; cfg_img_w = CW'(8); cfg_img_h = RW'(8); win_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k != 0) @(negedge clk);
      s_valid = 1'b1; s_data = pix(k);
    end
    @(negedge clk);
    s_valid = 1'b0; s_data = '0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t4 reset mid-frame", {s_ready, lb_en, win_valid, busy, done, cfg_err, win_row, win_col}, '0);
    fill_t1();
    apply_table("t4");

    run_frame("t5", 6, 5, 1, 0, 0);
`ifdef STRIDE2_EN
    run_frame("t6", 7, 7, 0, 0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
